// File: rtl/pipelined_controller.sv
// Purpose : ID-stage decoder plus ID/EX, EX/MEM and MEM/WB control pipeline with load-use bubbles.
// Latency : decode visible on id_ex_* after 1 edge, ex_mem_* after 2, mem_wb_* after 3.
// Backpressure: stall_in freezes every register; a load-use hazard holds PC and IF/ID and injects one bubble.
//
// Ports:
//   clk, rst_n (synchronous, active-low)
//   instr_valid / instruction : IF/ID register contents
//   stall_in / flush_in       : global freeze, branch-taken squash
//   pc_write_en, if_id_write_en, if_id_flush, jump_register : combinational front-end controls
//   id_ex_*, ex_mem_*, mem_wb_* : registered control bundles and destination registers
// Optional macro CTRL_ILLEGAL_TRAP_EN adds the sticky registered output illegal_instr.
module pipelined_controller #(
    parameter int ALUOP_W       = 6,
    parameter int REG_ADDR_W    = 5,
    parameter int HAZARD_DETECT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid,
    input  logic [31:0]           instruction,
    input  logic                  stall_in,
    input  logic                  flush_in,
    output logic                  pc_write_en,
    output logic                  if_id_write_en,
    output logic                  if_id_flush,
    output logic                  jump_register,
    output logic                  id_ex_valid,
    output logic [1:0]            id_ex_wb,
    output logic [2:0]            id_ex_mem,
    output logic [3:0]            id_ex_ex,
    output logic [ALUOP_W-1:0]    id_ex_aluop,
    output logic [REG_ADDR_W-1:0] id_ex_rt,
    output logic [REG_ADDR_W-1:0] id_ex_dst,
    output logic                  ex_mem_valid,
    output logic [1:0]            ex_mem_wb,
    output logic [2:0]            ex_mem_mem,
    output logic [REG_ADDR_W-1:0] ex_mem_dst,
    output logic                  mem_wb_valid,
    output logic [1:0]            mem_wb_wb,
    output logic [REG_ADDR_W-1:0] mem_wb_dst
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                  illegal_instr
`endif
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            wb;
        logic [2:0]            mem;
        logic [3:0]            ex;
        logic [ALUOP_W-1:0]    aluop;
        logic [REG_ADDR_W-1:0] rt;
        logic [REG_ADDR_W-1:0] dst;
    } id_ex_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            wb;
        logic [2:0]            mem;
        logic [REG_ADDR_W-1:0] dst;
    } ex_mem_t;

    typedef struct packed {
        logic                  valid;
        logic [1:0]            wb;
        logic [REG_ADDR_W-1:0] dst;
    } mem_wb_t;

    // Per-edge action, highest priority first (reset handled in the register process).
    typedef enum logic [1:0] {
        MODE_STALL,
        MODE_FLUSH,
        MODE_HAZARD,
        MODE_NORMAL
    } mode_e;

    id_ex_t  id_ex_q,  id_ex_d;
    ex_mem_t ex_mem_q, ex_mem_d;
    mem_wb_t mem_wb_q, mem_wb_d;

    id_ex_t  dec;
    logic    dec_reads_rt;
    logic    dec_jr;
    logic    load_use;
    logic    hazard;
    mode_e   mode;

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs_f;
    logic [REG_ADDR_W-1:0] rt_f;
    logic [REG_ADDR_W-1:0] rd_f;

    assign opcode = instruction[31:26];
    assign funct  = instruction[5:0];
    assign rs_f   = REG_ADDR_W'(instruction[25:21]);
    assign rt_f   = REG_ADDR_W'(instruction[20:16]);
    assign rd_f   = REG_ADDR_W'(instruction[15:11]);

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic dec_illegal;
    logic illegal_q, illegal_d;
`endif

    // ID decode. Invalid slots, the all-zero nop and unknown opcodes all become bubbles.
    always_comb begin
        dec          = '0;
        dec_reads_rt = 1'b0;
        dec_jr       = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        dec_illegal  = 1'b0;
`endif
        if (instr_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    if (instruction != '0) begin
                        dec.valid = 1'b1;
                        if (funct == FUNCT_JR) begin
                            dec.ex = 4'b1000;
                            dec_jr = 1'b1;
                        end else begin
                            dec.wb       = 2'b11;
                            dec.ex       = 4'b0001;
                            dec.aluop    = ALUOP_W'(funct);
                            dec_reads_rt = 1'b1;
                        end
                    end
                end
                OP_LW: begin
                    dec.valid = 1'b1;
                    dec.wb    = 2'b10;
                    dec.mem   = 3'b010;
                    dec.ex    = 4'b0010;
                    dec.aluop = ALUOP_W'(6'h20);
                end
                OP_SW: begin
                    dec.valid    = 1'b1;
                    dec.mem      = 3'b001;
                    dec.ex       = 4'b0010;
                    dec.aluop    = ALUOP_W'(6'h20);
                    dec_reads_rt = 1'b1;
                end
                OP_BEQ: begin
                    dec.valid    = 1'b1;
                    dec.mem      = 3'b100;
                    dec.ex       = 4'b0100;
                    dec.aluop    = ALUOP_W'(6'h22);
                    dec_reads_rt = 1'b1;
                end
                OP_ADDI: begin
                    dec.valid = 1'b1;
                    dec.wb    = 2'b11;
                    dec.ex    = 4'b0010;
                    dec.aluop = ALUOP_W'(6'h20);
                end
                default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    dec_illegal = 1'b1;
`endif
                end
            endcase
        end
        if (dec.valid) begin
            dec.rt = rt_f;
        end
        // Non-writing entries carry dst 0 so forwarding logic never matches them.
        if (dec.wb[1]) begin
            dec.dst = dec.ex[0] ? rd_f : rt_f;
        end
    end

    // A load in EX whose target is read by the instruction now in ID.
    always_comb begin
        load_use = id_ex_q.valid && id_ex_q.mem[1] && (id_ex_q.rt != '0) && instr_valid &&
                   ((id_ex_q.rt == rs_f) || ((id_ex_q.rt == rt_f) && dec_reads_rt));
        hazard   = (HAZARD_DETECT != 0) && load_use;
    end

    always_comb begin
        if (stall_in) begin
            mode = MODE_STALL;
        end else if (flush_in) begin
            mode = MODE_FLUSH;
        end else if (hazard) begin
            mode = MODE_HAZARD;
        end else begin
            mode = MODE_NORMAL;
        end
    end

    always_comb begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        jump_register  = 1'b0;
        id_ex_d        = id_ex_q;
        ex_mem_d       = ex_mem_q;
        mem_wb_d       = mem_wb_q;

        if (mode != MODE_STALL) begin
            ex_mem_d.valid = id_ex_q.valid;
            ex_mem_d.wb    = id_ex_q.wb;
            ex_mem_d.mem   = id_ex_q.mem;
            ex_mem_d.dst   = id_ex_q.dst;
            mem_wb_d.valid = ex_mem_q.valid;
            mem_wb_d.wb    = ex_mem_q.wb;
            mem_wb_d.dst   = ex_mem_q.dst;
        end

        case (mode)
            MODE_STALL: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
            end
            MODE_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_d     = '0;
            end
            MODE_HAZARD: begin
                pc_write_en    = 1'b0;
                if_id_write_en = 1'b0;
                id_ex_d        = '0;
            end
            default: begin
                id_ex_d = dec;
                // JR redirects the PC from ID, so the sequentially fetched word is discarded.
                jump_register = dec_jr;
                if_id_flush   = dec_jr;
            end
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    always_comb begin
        illegal_d = illegal_q;
        if (dec_illegal && (mode != MODE_STALL) && (mode != MODE_FLUSH)) begin
            illegal_d = 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= 1'b0;
`endif
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= ex_mem_d;
            mem_wb_q <= mem_wb_d;
`ifdef CTRL_ILLEGAL_TRAP_EN
            illegal_q <= illegal_d;
`endif
        end
    end

    assign id_ex_valid  = id_ex_q.valid;
    assign id_ex_wb     = id_ex_q.wb;
    assign id_ex_mem    = id_ex_q.mem;
    assign id_ex_ex     = id_ex_q.ex;
    assign id_ex_aluop  = id_ex_q.aluop;
    assign id_ex_rt     = id_ex_q.rt;
    assign id_ex_dst    = id_ex_q.dst;
    assign ex_mem_valid = ex_mem_q.valid;
    assign ex_mem_wb    = ex_mem_q.wb;
    assign ex_mem_mem   = ex_mem_q.mem;
    assign ex_mem_dst   = ex_mem_q.dst;
    assign mem_wb_valid = mem_wb_q.valid;
    assign mem_wb_wb    = mem_wb_q.wb;
    assign mem_wb_dst   = mem_wb_q.dst;
`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_pipelined_controller.sv
// Purpose : self-checking bench for pipelined_controller against a table-driven pipeline model.
// Latency : inputs driven 1 time unit after posedge, combinational outputs sampled at negedge, registers 1 unit after posedge.
// Backpressure: random stall_in/flush_in; flush is held while stalled, as its source would.
module tb_pipelined_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instruction;
    logic        stall_in;
    logic        flush_in;
    logic        pc_write_en, if_id_write_en, if_id_flush, jump_register;
    logic        id_ex_valid;
    logic [1:0]  id_ex_wb;
    logic [2:0]  id_ex_mem;
    logic [3:0]  id_ex_ex;
    logic [5:0]  id_ex_aluop;
    logic [4:0]  id_ex_rt, id_ex_dst;
    logic        ex_mem_valid;
    logic [1:0]  ex_mem_wb;
    logic [2:0]  ex_mem_mem;
    logic [4:0]  ex_mem_dst;
    logic        mem_wb_valid;
    logic [1:0]  mem_wb_wb;
    logic [4:0]  mem_wb_dst;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic        illegal_instr;
`endif

    always #5 clk = ~clk;

    pipelined_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .stall_in       (stall_in),
        .flush_in       (flush_in),
        .pc_write_en    (pc_write_en),
        .if_id_write_en (if_id_write_en),
        .if_id_flush    (if_id_flush),
        .jump_register  (jump_register),
        .id_ex_valid    (id_ex_valid),
        .id_ex_wb       (id_ex_wb),
        .id_ex_mem      (id_ex_mem),
        .id_ex_ex       (id_ex_ex),
        .id_ex_aluop    (id_ex_aluop),
        .id_ex_rt       (id_ex_rt),
        .id_ex_dst      (id_ex_dst),
        .ex_mem_valid   (ex_mem_valid),
        .ex_mem_wb      (ex_mem_wb),
        .ex_mem_mem     (ex_mem_mem),
        .ex_mem_dst     (ex_mem_dst),
        .mem_wb_valid   (mem_wb_valid),
        .mem_wb_wb      (mem_wb_wb),
        .mem_wb_dst     (mem_wb_dst)
`ifdef CTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_instr  (illegal_instr)
`endif
    );

    typedef struct {
        bit       v;
        bit [1:0] wb;
        bit [2:0] mem;
        bit [3:0] ex;
        bit [5:0] alu;
        bit [4:0] rt;
        bit [4:0] dst;
    } ent_t;

    // pipe[0] = ID/EX, pipe[1] = EX/MEM, pipe[2] = MEM/WB
    ent_t pipe [3];
    bit   m_illegal;
    int   total = 0;
    int   bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Straight transcription of the decode table.
    function automatic ent_t model_decode(input bit ivld, input bit [31:0] ins,
                                          output bit rd_rt, output bit jr, output bit ill);
        ent_t e;
        e     = '{default: 0};
        rd_rt = 0;
        jr    = 0;
        ill   = 0;
        if (ivld) begin
            case (ins[31:26])
                6'h00: begin
                    if (ins == 32'd0) begin
                        e.v = 0;
                    end else if (ins[5:0] == 6'h08) begin
                        e.v = 1; e.ex = 4'b1000; jr = 1;
                    end else begin
                        e.v = 1; e.wb = 2'b11; e.ex = 4'b0001; e.alu = ins[5:0]; rd_rt = 1;
                    end
                end
                6'h23: begin e.v = 1; e.wb = 2'b10; e.mem = 3'b010; e.ex = 4'b0010; e.alu = 6'h20; end
                6'h2B: begin e.v = 1; e.mem = 3'b001; e.ex = 4'b0010; e.alu = 6'h20; rd_rt = 1; end
                6'h04: begin e.v = 1; e.mem = 3'b100; e.ex = 4'b0100; e.alu = 6'h22; rd_rt = 1; end
                6'h08: begin e.v = 1; e.wb = 2'b11; e.ex = 4'b0010; e.alu = 6'h20; end
                default: ill = 1;
            endcase
        end
        if (e.v) e.rt = ins[20:16];
        if (e.wb[1]) e.dst = e.ex[0] ? ins[15:11] : ins[20:16];
        return e;
    endfunction

    task automatic step(input bit rn, input bit st, input bit fl, input bit iv, input bit [31:0] ins);
        ent_t d, bub;
        bit   rd_rt, jr, ill, haz;
        bub = '{default: 0};
        rst_n = rn; stall_in = st; flush_in = fl; instr_valid = iv; instruction = ins;
        d   = model_decode(iv, ins, rd_rt, jr, ill);
        haz = pipe[0].v && pipe[0].mem[1] && (pipe[0].rt != 0) && iv &&
              ((pipe[0].rt == ins[25:21]) || ((pipe[0].rt == ins[20:16]) && rd_rt));
        #4;
        if (rn) begin
            if (st) begin
                check_eq("stall_pc",   pc_write_en,    0);
                check_eq("stall_ifwe", if_id_write_en, 0);
                check_eq("stall_ifid_flush", if_id_flush, 0);
                check_eq("stall_jr",   jump_register,  0);
            end else if (fl) begin
                check_eq("flush_pc",   pc_write_en,    1);
                check_eq("flush_ifid_flush", if_id_flush, 1);
                check_eq("flush_jr",   jump_register,  0);
            end else if (haz) begin
                check_eq("haz_pc",     pc_write_en,    0);
                check_eq("haz_ifwe",   if_id_write_en, 0);
                check_eq("haz_ifid_flush", if_id_flush, 0);
                check_eq("haz_jr",     jump_register,  0);
            end else begin
                check_eq("norm_pc",    pc_write_en,    1);
                check_eq("norm_ifwe",  if_id_write_en, 1);
                check_eq("norm_ifid_flush", if_id_flush, jr);
                check_eq("norm_jr",    jump_register,  jr);
            end
        end
        @(posedge clk);
        if (!rn) begin
            pipe[0] = bub; pipe[1] = bub; pipe[2] = bub; m_illegal = 0;
        end else if (!st) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (fl || haz) ? bub : d;
            if (ill && !fl) m_illegal = 1;
        end
        #1;
        check_eq("id_ex_valid",  id_ex_valid,  pipe[0].v);
        check_eq("id_ex_wb",     id_ex_wb,     pipe[0].wb);
        check_eq("id_ex_mem",    id_ex_mem,    pipe[0].mem);
        check_eq("id_ex_ex",     id_ex_ex,     pipe[0].ex);
        check_eq("id_ex_aluop",  id_ex_aluop,  pipe[0].alu);
        check_eq("id_ex_dst",    id_ex_dst,    pipe[0].dst);
        if (pipe[0].v) check_eq("id_ex_rt", id_ex_rt, pipe[0].rt);
        check_eq("ex_mem_valid", ex_mem_valid, pipe[1].v);
        check_eq("ex_mem_wb",    ex_mem_wb,    pipe[1].wb);
        check_eq("ex_mem_mem",   ex_mem_mem,   pipe[1].mem);
        check_eq("ex_mem_dst",   ex_mem_dst,   pipe[1].dst);
        check_eq("mem_wb_valid", mem_wb_valid, pipe[2].v);
        check_eq("mem_wb_wb",    mem_wb_wb,    pipe[2].wb);
        check_eq("mem_wb_dst",   mem_wb_dst,   pipe[2].dst);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_eq("illegal_instr", illegal_instr, m_illegal);
`endif
    endtask

    function automatic bit [31:0] rand_instr();
        bit [4:0] rs, rt, rd;
        bit [5:0] fn;
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 5))
            0: fn = 6'h20;
            1: fn = 6'h22;
            2: fn = 6'h24;
            3: fn = 6'h25;
            4: fn = 6'h2A;
            default: fn = 6'h00;
        endcase
        case ($urandom_range(0, 10))
            0, 1: return {6'h00, rs, rt, rd, 5'($urandom_range(0, 1)), fn};
            2:    return {6'h00, rs, 15'd0, 6'h08};
            3, 9: return {6'h23, rs, rt, 16'($urandom)};
            4:    return {6'h2B, rs, rt, 16'($urandom)};
            5:    return {6'h04, rs, rt, 16'($urandom)};
            6:    return {6'h08, rs, rt, 16'($urandom)};
            7:    return 32'd0;
            8:    return {6'h3F, rs, rt, 16'($urandom)};
            default: return {6'h02, 26'($urandom)};
        endcase
    endfunction

    localparam bit [31:0] I_ADD  = 32'h012A4020;
    localparam bit [31:0] I_LW   = 32'h8D280000;
    localparam bit [31:0] I_USE  = 32'h01095020;
    localparam bit [31:0] I_JR   = 32'h03E00008;
    localparam bit [31:0] I_SW   = 32'hAD280004;
    localparam bit [31:0] I_BEQ  = 32'h11090003;

    initial begin
        bit st, fl, prev_st, prev_fl;
        pipe[0] = '{default: 0}; pipe[1] = '{default: 0}; pipe[2] = '{default: 0};
        m_illegal = 0;
        rst_n = 0; stall_in = 0; flush_in = 0; instr_valid = 0; instruction = 0;
        @(posedge clk); #1;

        // Reset with a live add in IF/ID, then release.
        step(0, 0, 0, 1, I_ADD);
        step(0, 0, 0, 1, I_ADD);
        check_eq("rst_id_ex_valid",  id_ex_valid,  0);
        check_eq("rst_mem_wb_valid", mem_wb_valid, 0);
        step(1, 0, 0, 1, I_ADD);
        check_eq("add_wb",    id_ex_wb,    2'b11);
        check_eq("add_ex",    id_ex_ex,    4'b0001);
        check_eq("add_aluop", id_ex_aluop, 6'h20);
        check_eq("add_dst",   id_ex_dst,   5'd8);
        step(1, 0, 0, 1, I_ADD);
        step(1, 0, 0, 1, I_ADD);
        check_eq("add_mem_wb_valid", mem_wb_valid, 1);

        // Load-use: one bubble, then the consumer enters ID/EX.
        step(1, 0, 0, 1, I_LW);
        step(1, 0, 0, 1, I_USE);
        check_eq("lu_bubble", id_ex_valid, 0);
        step(1, 0, 0, 1, I_USE);
        check_eq("lu_enter_valid", id_ex_valid, 1);
        check_eq("lu_enter_dst",   id_ex_dst,   5'd10);

        // JR
        step(1, 0, 0, 1, I_JR);
        check_eq("jr_wb", id_ex_wb, 2'b00);
        check_eq("jr_ex", id_ex_ex, 4'b1000);

        // Flush during stall is ignored until the stall drops.
        step(1, 1, 1, 1, I_ADD);
        check_eq("stflush_hold", id_ex_ex, 4'b1000);
        step(1, 0, 1, 1, I_ADD);
        check_eq("flush_bubble", id_ex_valid, 0);

        // sw then beq
        step(1, 0, 0, 1, I_SW);
        step(1, 0, 0, 1, I_BEQ);
        check_eq("sw_ex_mem_mem", ex_mem_mem, 3'b001);
        check_eq("beq_aluop",     id_ex_aluop, 6'h22);
        step(1, 0, 0, 1, 32'd0);
        check_eq("beq_ex_mem_mem", ex_mem_mem, 3'b100);
        check_eq("sw_mem_wb_wb",   mem_wb_wb,  2'b00);
        step(1, 0, 0, 0, 32'd0);
        check_eq("beq_mem_wb_wb",  mem_wb_wb,  2'b00);

`ifdef CTRL_ILLEGAL_TRAP_EN
        step(1, 0, 0, 1, 32'hFC000000);
        check_eq("ill_set", illegal_instr, 1);
        check_eq("ill_bubble", id_ex_valid, 0);
        step(1, 0, 0, 1, I_ADD);
        step(1, 0, 0, 1, I_SW);
        check_eq("ill_sticky", illegal_instr, 1);
        step(0, 0, 0, 1, I_ADD);
        check_eq("ill_clear", illegal_instr, 0);
`endif

        // Randomized traffic.
        prev_st = 0; prev_fl = 0;
        for (int i = 0; i < 2000; i++) begin
            st = ($urandom_range(0, 99) < 12);
            fl = (prev_fl && prev_st) ? 1'b1 : ($urandom_range(0, 99) < 8);
            step(($urandom_range(0, 199) != 0), st, fl, ($urandom_range(0, 9) != 0), rand_instr());
            prev_st = st;
            prev_fl = fl;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Pipelined successor to the single-cycle R-type decoder.
- Decodes R-type, JR, lw, sw, beq and addi in the ID stage.
- Carries WB/MEM/EX control bundles and the destination register through the ID/EX, EX/MEM and MEM/WB registers.
- Detects load-use hazards and inserts bubbles. Applies external stall and flush requests.
- Sits between the IF/ID instruction register and the datapath pipeline registers.

Parameters:
- ALUOP_W, 6, ALU operation code width. Funct code is zero-extended or truncated to this width.
- REG_ADDR_W, 5, register-address width for rs/rt/rd fields and destination outputs.
- HAZARD_DETECT, 1, 1 enables load-use stall generation; 0 ties the hazard signal to 0.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous reset, active-low
- instr_valid  in  1  IF/ID holds a real instruction
- instruction  in  32  IF/ID instruction
- stall_in  in  1  global freeze (memory wait)
- flush_in  in  1  branch taken in EX; squash ID and IF/ID
- pc_write_en  out  1  PC may advance
- if_id_write_en  out  1  IF/ID may load
- if_id_flush  out  1  clear IF/ID next edge
- jump_register  out  1  combinational: valid JR in ID, not stalled/flushed
- id_ex_valid, id_ex_wb[1:0], id_ex_mem[2:0], id_ex_ex[3:0], id_ex_aluop[ALUOP_W-1:0], id_ex_rt[REG_ADDR_W-1:0], id_ex_dst[REG_ADDR_W-1:0]  out  registered ID/EX control
- ex_mem_valid, ex_mem_wb[1:0], ex_mem_mem[2:0], ex_mem_dst[REG_ADDR_W-1:0]  out  registered EX/MEM control
- mem_wb_valid, mem_wb_wb[1:0], mem_wb_dst[REG_ADDR_W-1:0]  out  registered MEM/WB control

Behaviour:
- Bundle encodings:
  - WB[1] = reg_write; WB[0] = 1 selects ALU result, 0 selects memory data.
  - MEM[2] = branch; MEM[1] = mem_read; MEM[0] = mem_write.
  - EX[0] = dst is rd (else rt); EX[1] = ALU src is immediate; EX[2] = branch; EX[3] = jump.
- Decode table:
  - R-type (op 0, funct ≠ 8, instruction ≠ 0): WB=11, MEM=000, EX=0001, ALUop=funct. This includes shifts with funct 0.
  - instruction == 0: bubble.
  - JR (op 0, funct 8): WB=00, MEM=000, EX=1000, ALUop=0, jump_register=1.
  - lw 0x23: WB=10, MEM=010, EX=0010, ALUop=0x20.
  - sw 0x2B: WB=00, MEM=001, EX=0010, ALUop=0x20.
  - beq 0x04: WB=00, MEM=100, EX=0100, ALUop=0x22.
  - addi 0x08: WB=11, MEM=000, EX=0010, ALUop=0x20.
  - Any other opcode: bubble.
- Bubble: valid=0 and all bundles 0. A stage with valid=0 must present zero bundles.
- Destination: dst = rd if EX[0], else rt. Destination is forced to 0 when WB[1] = 0.
- Reset: when rst_n is low at a clock edge, all valid bits and all registered outputs become 0. This holds regardless of other inputs, including mid-stall or mid-flush.
- Latency: ID decode appears on id_ex_* 1 cycle later, ex_mem_* 2 cycles later, mem_wb_* 3 cycles later.
- Load-use hazard: asserted when all of the following hold:
  - id_ex_valid, id_ex_mem[1], and id_ex_rt ≠ 0;
  - instr_valid;
  - id_ex_rt == rs, or (id_ex_rt == rt and the ID instruction reads rt: R-type, sw, beq).
- Priority per edge: reset > stall_in > flush_in > hazard > normal.
  - stall_in=1: every pipeline register holds. pc_write_en=0, if_id_write_en=0, if_id_flush=0, jump_register=0. flush_in is ignored; its source holds it until stall_in drops.
  - flush_in=1: ID/EX loads a bubble; EX/MEM and MEM/WB advance; if_id_flush=1; pc_write_en=1; jump_register=0.
  - hazard: ID/EX loads a bubble; EX/MEM and MEM/WB advance; pc_write_en=0; if_id_write_en=0; jump_register=0. Lasts exactly one cycle per lw.
  - normal: all stages advance; pc_write_en=1; if_id_write_en=1.
- JR in ID: jump_register=1 and if_id_flush=1. JR itself enters ID/EX as a non-writing entry with valid=1.
- instr_valid=0: ID decodes as a bubble; no hazard is raised.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Adds output illegal_instr (1 bit, registered, sticky).
  - Set on the first edge where instr_valid=1, the opcode is undecodable, and there is no stall or flush.
  - Cleared only by reset.
  - The offending instruction still enters ID/EX as a bubble.
- Not defined: the port is absent and undecodable opcodes become silent bubbles.

Test Plan:
- Reset: hold rst_n=0 two cycles with instruction=add (0x012A4020) -> all *_valid=0, all bundles 0. Release -> id_ex_wb=11, id_ex_ex=0001, id_ex_aluop=0x20, id_ex_dst=8 after 1 edge; mem_wb_valid=1 at edge 3.
- Load-use: lw $t0 (0x8D280000), then add using $t0 as rs (0x01095020) -> one cycle with pc_write_en=0 and id_ex_valid=0 bubble; add enters ID/EX on the following edge.
- JR: instruction 0x03E00008 -> jump_register=1 and if_id_flush=1 that cycle; next edge id_ex_wb=00, id_ex_ex=1000.
- Flush vs stall: flush_in=1 and stall_in=1 together -> all registers hold, if_id_flush=0. Drop stall_in with flush_in held -> id_ex_valid=0 and if_id_flush=1.
- sw then beq: 0xAD280004 then 0x11090003 -> ex_mem_mem=001 then 100; mem_wb_wb=00 for both; beq ALUop=0x22.
- With CTRL_ILLEGAL_TRAP_EN: opcode 0x3F -> illegal_instr=1 next edge and stays 1 through later valid instructions until rst_n=0.
